lpc_frame_sched: RTL and testbench



---
 rtl/lpc_pkg.sv | 19 +
 rtl/lpc_param_bank.sv | 95 +++++++++
 rtl/lpc_frame_sched.sv | 149 ++++++++++++++
 tb/tb_lpc_frame_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// lpc_pkg
// Shared definitions for the LPC frame scheduler slice.
//   state_t  : scheduler states IDLE / RUN / DRAIN
//   ADDR_A0  : shadow write address of coefficient A0 (A0..A10 follow)
//   ADDR_VP  : shadow write address of the {voiced, pulserate} word
//   NCOEF    : number of filter coefficients (ten-plus-one)
package lpc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] ADDR_A0 = 4'd0;
   localparam logic [3:0] ADDR_VP = 4'd11;
   localparam int         NCOEF   = 11;

endpackage

// File: rtl/lpc_param_bank.sv
// lpc_param_bank
// Shadow and active LPC parameter sets. The host fills the shadow set word
// by word and marks it complete with commit; swap copies it into the active
// set and frees the shadow for the next frame.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data: shadow write port (0-10 coefs, 11 voiced+rate)
//   commit              : marks the shadow set complete
//   swap                : copy shadow to active and clear shadow_full
//   coef                : active A0..A10, A0 in the LSBs
//   voiced, pulserate   : active voiced flag and zero-extended pulse rate
//   shadow_full         : shadow set is complete and waiting for a swap
module lpc_param_bank
   import lpc_pkg::*;
#(
   parameter int COEF_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [3:0]              wr_addr,
   input  logic [15:0]             wr_data,
   input  logic                    commit,
   input  logic                    swap,
   output logic [NCOEF*COEF_W-1:0] coef,
   output logic                    voiced,
   output logic [15:0]             pulserate,
   output logic                    shadow_full
);

   logic [COEF_W-1:0] shadow_coef [NCOEF];
   logic [COEF_W-1:0] active_coef [NCOEF];
   logic              shadow_voiced;
   logic [14:0]       shadow_rate;
   logic              active_voiced;
   logic [14:0]       active_rate;
   logic              wr_ok;
   logic signed [15:0] wr_data_s;
   logic [COEF_W-1:0] wr_coef;

   // Writes are only taken while the shadow is still open; once committed
   // the set is frozen until the scheduler swaps it out.
   assign wr_ok     = wr_en && !shadow_full;
   assign wr_data_s = wr_data;
   assign wr_coef   = COEF_W'(wr_data_s);

   // Shadow register file and the full flag. A swap and a commit can never
   // coincide because one needs the flag set and the other needs it clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) shadow_coef[i] <= '0;
         shadow_voiced <= 1'b0;
         shadow_rate   <= '0;
         shadow_full   <= 1'b0;
      end else begin
         if (wr_ok) begin
            if (wr_addr == ADDR_VP) begin
               shadow_voiced <= wr_data[15];
               shadow_rate   <= wr_data[14:0];
            end else if (wr_addr < ADDR_VP) begin
               shadow_coef[wr_addr - ADDR_A0] <= wr_coef;
            end
         end
         if (swap) begin
            shadow_full <= 1'b0;
         end else if (commit && !shadow_full) begin
            shadow_full <= 1'b1;
         end
      end
   end

   // Active set only ever changes on a swap, so the decoder sees stable
   // parameters for the whole frame and through the stop tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) active_coef[i] <= '0;
         active_voiced <= 1'b0;
         active_rate   <= '0;
      end else if (swap) begin
         for (int i = 0; i < NCOEF; i++) active_coef[i] <= shadow_coef[i];
         active_voiced <= shadow_voiced;
         active_rate   <= shadow_rate;
      end
   end

   // Flatten the active coefficients onto the output bus, A0 lowest.
   always_comb begin
      coef = '0;
      for (int i = 0; i < NCOEF; i++) coef[i*COEF_W +: COEF_W] = active_coef[i];
   end

   assign voiced    = active_voiced;
   assign pulserate = {1'b0, active_rate};

endmodule

// File: rtl/lpc_frame_sched.sv
// lpc_frame_sched
// Frame scheduler for the LPC decoder: sequences start/stop, counts decoded
// samples per frame, and swaps the shadow parameter set in at frame starts
// and frame boundaries.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : permits starting and continuing frames
//   frame_len           : samples per frame (0 acts as 1), sampled at swaps
//   sample_tick         : one pulse per decoded sample
//   wr_en/wr_addr/wr_data/commit : shadow loader interface
//   wr_ready            : shadow set open for writes
//   coef/voiced/pulserate : active parameter set to the decoder
//   start, stop         : one-cycle decoder control pulses
//   frame_done          : one-cycle pulse at each frame end
//   underrun            : frame ended while enabled with no shadow ready
//   busy                : high in RUN or DRAIN
module lpc_frame_sched
   import lpc_pkg::*;
#(
   parameter int COEF_W = 16,
   parameter int LEN_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [LEN_W-1:0]        frame_len,
   input  logic                    sample_tick,
   input  logic                    wr_en,
   input  logic [3:0]              wr_addr,
   input  logic [15:0]             wr_data,
   input  logic                    commit,
   output logic                    wr_ready,
   output logic [NCOEF*COEF_W-1:0] coef,
   output logic                    voiced,
   output logic [15:0]             pulserate,
   output logic                    start,
   output logic                    stop,
   output logic                    frame_done,
   output logic                    underrun,
   output logic                    busy
);

   state_t           state, state_next;
   logic [LEN_W-1:0] cnt, cnt_next;
   logic [LEN_W-1:0] len_q, len_next;
   logic [LEN_W-1:0] len_eff;
   logic             at_last;
   logic             swap;
   logic             shadow_full;
   logic             start_next, stop_next, done_next, underrun_next;

   lpc_param_bank #(.COEF_W(COEF_W)) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .commit      (commit),
      .swap        (swap),
      .coef        (coef),
      .voiced      (voiced),
      .pulserate   (pulserate),
      .shadow_full (shadow_full)
   );

   // A zero length would never reach its last sample, so it runs as one.
   assign len_eff  = (frame_len == '0) ? LEN_W'(1) : frame_len;
   assign at_last  = (cnt == len_q - LEN_W'(1));
   assign busy     = (state != IDLE);
   assign wr_ready = !shadow_full;

   // State, counter, latched length and the registered control pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         len_q      <= '0;
         start      <= 1'b0;
         stop       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         len_q      <= len_next;
         start      <= start_next;
         stop       <= stop_next;
         frame_done <= done_next;
         underrun   <= underrun_next;
      end
   end

   // Next-state logic. The same counter counts samples in RUN and clock
   // cycles of the stop tail in DRAIN; it is cleared on every transition.
   // A frame boundary with a ready shadow swaps and keeps running without
   // a new start pulse; otherwise the decoder is stopped and drained.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      len_next      = len_q;
      swap          = 1'b0;
      start_next    = 1'b0;
      stop_next     = 1'b0;
      done_next     = 1'b0;
      underrun_next = 1'b0;
      case (state)
         IDLE: begin
            if (enable && shadow_full) begin
               swap       = 1'b1;
               len_next   = len_eff;
               cnt_next   = '0;
               start_next = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (sample_tick) begin
               if (at_last) begin
                  done_next = 1'b1;
                  cnt_next  = '0;
                  if (enable && shadow_full) begin
                     swap     = 1'b1;
                     len_next = len_eff;
                  end else begin
                     stop_next     = 1'b1;
                     underrun_next = enable;
                     state_next    = DRAIN;
                  end
               end else begin
                  cnt_next = cnt + LEN_W'(1);
               end
            end
         end
         DRAIN: begin
            if (at_last) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + LEN_W'(1);
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lpc_frame_sched.sv
// tb_lpc_frame_sched
// Self-checking bench for lpc_frame_sched. A parameter-set model (shadow,
// active, full flag) is updated from the loader rules and frame timing is
// predicted from the frame length alone.
module tb_lpc_frame_sched;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [15:0]  frame_len;
   logic         sample_tick;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [15:0]  wr_data;
   logic         commit;
   logic         wr_ready;
   logic [175:0] coef;
   logic         voiced;
   logic [15:0]  pulserate;
   logic         start;
   logic         stop;
   logic         frame_done;
   logic         underrun;
   logic         busy;

   logic [175:0] m_shadow, m_active;
   logic [15:0]  m_shadow_vp, m_active_vp;
   bit           m_full;

   int tests_run;
   int tests_failed;

   lpc_frame_sched #(.COEF_W(16), .LEN_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_len   (frame_len),
      .sample_tick (sample_tick),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .commit      (commit),
      .wr_ready    (wr_ready),
      .coef        (coef),
      .voiced      (voiced),
      .pulserate   (pulserate),
      .start       (start),
      .stop        (stop),
      .frame_done  (frame_done),
      .underrun    (underrun),
      .busy        (busy)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the design wedges somewhere unbounded
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // One clock: outputs are sampled 1 ns after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_shadow    = '0;
      m_active    = '0;
      m_shadow_vp = '0;
      m_active_vp = '0;
      m_full      = 1'b0;
   endtask

   task automatic model_swap();
      m_active    = m_shadow;
      m_active_vp = m_shadow_vp;
      m_full      = 1'b0;
   endtask

   // One shadow write; the model drops it while the shadow set is full
   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
      if (!m_full) begin
         if (a < 4'd11) m_shadow[int'(a)*16 +: 16] = d;
         else if (a == 4'd11) m_shadow_vp = d;
      end
   endtask

   task automatic bus_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
      if (!m_full) m_full = 1'b1;
   endtask

   task automatic load_random_set();
      for (int i = 0; i < 11; i++) bus_write(4'(i), 16'($urandom));
      bus_write(4'(12 + $urandom_range(0, 3)), 16'($urandom));
      bus_write(4'd11, 16'($urandom));
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) cyc();
      model_reset();
      tests_run++; if (coef !== m_active) begin tests_failed++; $display("[TB] FAIL reset_coef: got %h expected %h", coef, m_active); end
      tests_run++; if ({voiced, pulserate} !== 17'd0) begin tests_failed++; $display("[TB] FAIL reset_vp: got %b/%h expected 0/0000", voiced, pulserate); end
      tests_run++; if ({start, stop, frame_done, underrun, busy} !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {start, stop, frame_done, underrun, busy}); end
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int n;
      enable = 1'b1; frame_len = 16'd4;
      for (int i = 0; i < 11; i++) bus_write(4'(i), 16'(i + 1));
      bus_write(4'd11, 16'h8032);
      bus_commit();
      tests_run++; if ({start, wr_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL basic_commit: start/wr_ready got %b expected 00", {start, wr_ready}); end
      cyc();
      model_swap();
      tests_run++; if (start !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_start: got %b expected 1", start); end
      tests_run++; if (coef !== m_active) begin tests_failed++; $display("[TB] FAIL basic_coef: got %h expected %h", coef, m_active); end
      tests_run++; if ({voiced, pulserate} !== {1'b1, 16'h0032}) begin tests_failed++; $display("[TB] FAIL basic_vp: got %b/%h expected 1/0032", voiced, pulserate); end
      tests_run++; if ({busy, wr_ready} !== 2'b11) begin tests_failed++; $display("[TB] FAIL basic_busy_ready: got %b expected 11", {busy, wr_ready}); end
      cyc();
      tests_run++; if (start !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_start_pulse: got %b expected 0", start); end
      for (int t = 0; t < 4; t++) begin
         tick();
         tests_run++; if (frame_done !== (t == 3)) begin tests_failed++; $display("[TB] FAIL basic_done_t%0d: got %b expected %b", t, frame_done, (t == 3)); end
      end
      tests_run++; if ({stop, underrun} !== 2'b11) begin tests_failed++; $display("[TB] FAIL basic_stop_underrun: got %b expected 11", {stop, underrun}); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc(); n++; end
      tests_run++; if (n != 4) begin tests_failed++; $display("[TB] FAIL basic_drain: got %0d cycles expected 4", n); end
   endtask

   task automatic test_back_to_back();
      int l1, l2, n;
      logic [15:0] a3_before;
      l1 = $urandom_range(2, 5); l2 = $urandom_range(2, 5);
      enable = 1'b1; frame_len = 16'(l1);
      load_random_set();
      bus_commit();
      cyc();
      model_swap();
      tests_run++; if (coef !== m_active) begin tests_failed++; $display("[TB] FAIL b2b_coef_a: got %h expected %h", coef, m_active); end
      load_random_set();
      bus_commit();
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_full: wr_ready got %b expected 0", wr_ready); end
      a3_before = m_shadow[3*16 +: 16];
      bus_write(4'd3, ~a3_before);
      for (int t = 0; t < l1 - 1; t++) begin
         tick();
         tests_run++; if (frame_done !== 1'b0 || coef !== m_active) begin tests_failed++; $display("[TB] FAIL b2b_mid_t%0d: done %b coef %h expected 0 %h", t, frame_done, coef, m_active); end
      end
      frame_len = 16'(l2);
      tick();
      model_swap();
      tests_run++; if ({frame_done, stop, start, underrun} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL b2b_boundary: done/stop/start/underrun got %b expected 1000", {frame_done, stop, start, underrun}); end
      tests_run++; if (coef !== m_active) begin tests_failed++; $display("[TB] FAIL b2b_coef_b: got %h expected %h", coef, m_active); end
      tests_run++; if (coef[3*16 +: 16] !== a3_before) begin tests_failed++; $display("[TB] FAIL b2b_drop_a3: got %h expected %h", coef[3*16 +: 16], a3_before); end
      tests_run++; if ({voiced, pulserate} !== {m_active_vp[15], 1'b0, m_active_vp[14:0]}) begin tests_failed++; $display("[TB] FAIL b2b_vp: got %b/%h expected %b/%h", voiced, pulserate, m_active_vp[15], {1'b0, m_active_vp[14:0]}); end
      tests_run++; if ({wr_ready, busy} !== 2'b11) begin tests_failed++; $display("[TB] FAIL b2b_ready: wr_ready/busy got %b expected 11", {wr_ready, busy}); end
      for (int t = 0; t < l2; t++) begin
         if (t == 1) enable = 1'b0;
         tick();
         tests_run++; if (frame_done !== (t == l2 - 1)) begin tests_failed++; $display("[TB] FAIL b2b_f2_t%0d: done got %b expected %b", t, frame_done, (t == l2 - 1)); end
      end
      tests_run++; if ({stop, underrun} !== 2'b10) begin tests_failed++; $display("[TB] FAIL b2b_f2_end: stop/underrun got %b expected 10", {stop, underrun}); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc(); n++; end
      tests_run++; if (n != l2) begin tests_failed++; $display("[TB] FAIL b2b_drain: got %0d cycles expected %0d", n, l2); end
      enable = 1'b1;
   endtask

   task automatic test_enable_drop();
      int l, n;
      logic [175:0] held;
      l = $urandom_range(2, 5);
      enable = 1'b1; frame_len = 16'(l);
      load_random_set();
      bus_commit();
      cyc();
      model_swap();
      held = m_active;
      load_random_set();
      bus_commit();
      enable = 1'b0;
      for (int t = 0; t < l; t++) tick();
      tests_run++; if ({frame_done, stop, underrun} !== 3'b110) begin tests_failed++; $display("[TB] FAIL drop_end: done/stop/underrun got %b expected 110", {frame_done, stop, underrun}); end
      tests_run++; if (coef !== held || wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_held: coef %h wr_ready %b expected %h 0", coef, wr_ready, held); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc(); n++; end
      tests_run++; if (n != l) begin tests_failed++; $display("[TB] FAIL drop_drain: got %0d cycles expected %0d", n, l); end
      repeat (3) begin
         cyc();
         tests_run++; if (start !== 1'b0 || coef !== held) begin tests_failed++; $display("[TB] FAIL drop_idle: start %b coef %h expected 0 %h", start, coef, held); end
      end
      frame_len = 16'd0; enable = 1'b1;
      cyc();
      model_swap();
      tests_run++; if (start !== 1'b1 || coef !== m_active || wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_start: start %b wr_ready %b coef %h expected 1 1 %h", start, wr_ready, coef, m_active); end
      tick();
      tests_run++; if ({frame_done, stop, underrun} !== 3'b111) begin tests_failed++; $display("[TB] FAIL zero_len_end: done/stop/underrun got %b expected 111", {frame_done, stop, underrun}); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc(); n++; end
      tests_run++; if (n != 1) begin tests_failed++; $display("[TB] FAIL zero_drain: got %0d cycles expected 1", n); end
   endtask

   task automatic test_random_frames();
      int l, n;
      for (int it = 0; it < 6; it++) begin
         l = $urandom_range(1, 6);
         enable = 1'b1; frame_len = 16'(l);
         load_random_set();
         bus_commit();
         cyc();
         model_swap();
         tests_run++; if (start !== 1'b1 || coef !== m_active) begin tests_failed++; $display("[TB] FAIL rnd%0d_start: start %b coef %h expected 1 %h", it, start, coef, m_active); end
         for (int t = 0; t < l; t++) begin
            repeat ($urandom_range(0, 2)) begin
               cyc();
               tests_run++; if (frame_done !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd%0d_gap: done/busy got %b%b expected 01", it, frame_done, busy); end
            end
            tick();
            tests_run++; if (frame_done !== (t == l - 1)) begin tests_failed++; $display("[TB] FAIL rnd%0d_t%0d: done got %b expected %b", it, t, frame_done, (t == l - 1)); end
         end
         tests_run++; if ({stop, underrun} !== 2'b11) begin tests_failed++; $display("[TB] FAIL rnd%0d_end: stop/underrun got %b expected 11", it, {stop, underrun}); end
         n = 0;
         while (busy === 1'b1 && n < 100) begin cyc(); n++; end
         tests_run++; if (n != l) begin tests_failed++; $display("[TB] FAIL rnd%0d_drain: got %0d cycles expected %0d", it, n, l); end
      end
   endtask

   task automatic test_reset_midrun();
      enable = 1'b1; frame_len = 16'd5;
      load_random_set();
      bus_commit();
      cyc();
      model_swap();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++; if (coef !== m_active || {voiced, pulserate} !== 17'd0) begin tests_failed++; $display("[TB] FAIL rst_params: coef %h vp %b/%h expected zero", coef, voiced, pulserate); end
      tests_run++; if ({start, stop, frame_done, underrun, busy} !== 5'b0 || wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_ctrl: got %b ready %b expected 00000 1", {start, stop, frame_done, underrun, busy}, wr_ready); end
      repeat (3) begin
         cyc();
         tests_run++; if (stop !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_hold: stop/busy got %b%b expected 00", stop, busy); end
      end
      rst_n = 1'b1;
      cyc();
      tests_run++; if (busy !== 1'b0 || start !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_release: busy/start got %b%b expected 00", busy, start); end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst_n = 1'b0; enable = 1'b0; frame_len = '0; sample_tick = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_enable_drop();
      test_random_frames();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
